// File: rtl/x_mem_arb.sv
// rtl/x_mem_arb.sv - two-master round-robin bus arbiter with transfer lock and slave watchdog
module x_mem_arb #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_valid,
    input  logic        i_m0_rnw,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    output logic        o_m0_accept,
    output logic [31:0] o_m0_data,
    input  logic        i_m1_valid,
    input  logic        i_m1_rnw,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    output logic        o_m1_accept,
    output logic [31:0] o_m1_data,
    output logic        o_valid,
    output logic        o_rnw,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    input  logic        i_accept,
    input  logic [31:0] i_data,
    output logic        o_owner,
    output logic        o_busy,
    output logic        o_timeout
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Counter wide enough to hold TIMEOUT itself; a disabled watchdog still gets a 1-bit counter.
    localparam int               CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic             WDOG_EN = (TIMEOUT != 0);

    logic [0:0]       state_q;
    logic             prio_q;
    logic             owner_q;
    logic [CNT_W-1:0] cnt_q;

    logic             busy;
    logic             own_valid;
    logic             own_rnw;
    logic [31:0]      own_addr;
    logic [31:0]      own_wdata;
    logic             to_hit;
    logic             own_accept;
    logic             abandon;
    logic             any_req;
    logic             winner;
    logic [31:0]      rdata;

    // Select the locked owner's request lines for forwarding to the slave.
    always_comb begin
        own_valid = i_m0_valid;
        own_rnw   = i_m0_rnw;
        own_addr  = i_m0_addr;
        own_wdata = i_m0_data;
        if (owner_q) begin
            own_valid = i_m1_valid;
            own_rnw   = i_m1_rnw;
            own_addr  = i_m1_addr;
            own_wdata = i_m1_data;
        end
    end

    // Transfer status: watchdog hit, completion and abandon; reset cycle never completes a transfer.
    always_comb begin
        busy       = (state_q == ST_BUSY);
        to_hit     = WDOG_EN & busy & own_valid & ~i_rst & (cnt_q == CNT_MAX) & ~i_accept;
        own_accept = busy & own_valid & ~i_rst & (i_accept | to_hit);
        abandon    = busy & ~own_valid;
        rdata      = to_hit ? ERR_DATA : i_data;
    end

    // Round-robin pick between simultaneous requesters; a lone requester always wins.
    always_comb begin
        any_req = i_m0_valid | i_m1_valid;
        winner  = (i_m0_valid & i_m1_valid) ? prio_q : i_m1_valid;
    end

    // Slave-side and master-side outputs; everything is quiet while idle.
    always_comb begin
        o_valid     = 1'b0;
        o_rnw       = 1'b0;
        o_addr      = 32'h0;
        o_data      = 32'h0;
        o_m0_accept = 1'b0;
        o_m1_accept = 1'b0;
        o_m0_data   = 32'h0;
        o_m1_data   = 32'h0;
        if (busy) begin
            o_valid = own_valid & ~to_hit;
            o_rnw   = own_rnw;
            o_addr  = own_addr;
            o_data  = own_wdata;
            if (owner_q) begin
                o_m1_accept = own_accept;
                o_m1_data   = rdata;
            end else begin
                o_m0_accept = own_accept;
                o_m0_data   = rdata;
            end
        end
        o_busy    = busy;
        o_owner   = owner_q;
        o_timeout = to_hit;
    end

    // Grant/lock state machine: grant from IDLE, release on completion or abandon.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (any_req) begin
                owner_q <= winner;
                state_q <= ST_BUSY;
            end
        end else begin
            if (abandon) begin
                state_q <= ST_IDLE;
            end else if (own_accept) begin
                state_q <= ST_IDLE;
                prio_q  <= ~owner_q;
            end
        end
    end

    // Watchdog: count slave wait cycles in BUSY, cleared on every new grant, saturating at the limit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            cnt_q <= '0;
        end else if (!i_accept && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
